result_drain: RTL and testbench

- Consumer at the output end of computing_core.
- Captures the full 896 x 10-bit result vector in one handshake and applies ReLU, arithmetic right-shift and 4-bit saturation to each result.
- Streams the requantized activations out in 14 beats of 64 lanes over a valid/ready interface to the activation write-back path.
- The output words are the 4-bit activations of the next layer.

---
 rtl/result_drain_pkg.sv | 33 +++
 rtl/result_drain_requant_lane.sv | 12 +
 rtl/result_drain.sv | 114 +++++++++++
 tb/tb_result_drain.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_pkg.sv
// Shared constants, FSM state type and the requantization rule for the
// result drain and later activation-side blocks.
package result_drain_pkg;

   localparam int NUM_RES   = 896;
   localparam int RES_W     = 10;
   localparam int LANES     = 64;
   localparam int OUT_W     = 4;
   localparam int SHIFT_W   = 3;
   localparam int NUM_BEATS = NUM_RES / LANES;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // ReLU, arithmetic right shift, then saturate into the unsigned 4-bit range.
   function automatic logic [OUT_W-1:0] requant(input logic signed [RES_W-1:0] x,
                                                input logic [SHIFT_W-1:0]      s);
      logic signed [RES_W-1:0] y;
      logic [OUT_W-1:0]        out;
      y = x >>> s;
      if (y[RES_W-1]) begin
         out = 4'd0;
      end else if (y > 10'sd15) begin
         out = 4'd15;
      end else begin
         out = y[OUT_W-1:0];
      end
      return out;
   endfunction

endpackage

// File: rtl/result_drain_requant_lane.sv
// One combinational requantization lane: signed result in, 4-bit activation out.
module requant_lane
   import result_drain_pkg::*;
(
   input  logic [RES_W-1:0]   x,
   input  logic [SHIFT_W-1:0] shift,
   output logic [OUT_W-1:0]   y
);

   assign y = requant(x, shift);

endmodule

// File: rtl/result_drain.sv
// Captures a full result vector in one handshake and streams it out as
// requantized 4-bit activations, 64 lanes per beat over valid/ready.
module result_drain
   import result_drain_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [NUM_RES*RES_W-1:0] i_result,
   input  logic [SHIFT_W-1:0]       i_shift,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [LANES*OUT_W-1:0]   o_data,
   output logic [3:0]               o_beat,
   output logic                     o_last,
   output logic [15:0]              o_frame_cnt
);

   state_t                   state;
   state_t                   state_next;
   logic [3:0]               beat;
   logic [3:0]               beat_next;
   logic [SHIFT_W-1:0]       shift;
   logic [15:0]              frame_cnt;
   logic [LANES*RES_W-1:0]   buffer [NUM_BEATS];
   logic [LANES*RES_W-1:0]   slice;
   logic [LANES*OUT_W-1:0]   lanes;
   logic                     is_last;
   logic                     xfer;
   logic                     capture;
   logic                     frame_done;

   assign o_valid     = (state == SEND);
   assign is_last     = (beat == 4'(NUM_BEATS - 1));
   assign o_last      = o_valid && is_last;
   assign xfer        = o_valid && i_ready;
   // Ready looks through i_ready on the last beat so chained frames leave no bubble.
   assign o_ready     = (state == IDLE) || (xfer && o_last);
   assign capture     = i_valid && o_ready;
   assign slice       = buffer[beat];
   assign o_data      = o_valid ? lanes : '0;
   assign o_beat      = beat;
   assign o_frame_cnt = frame_cnt;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      requant_lane u_lane (
         .x     (slice[l*RES_W +: RES_W]),
         .shift (shift),
         .y     (lanes[l*OUT_W +: OUT_W])
      );
   end

   always_comb begin
      state_next = state;
      beat_next  = beat;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (capture) begin
               state_next = SEND;
               beat_next  = 4'd0;
            end else begin
               state_next = IDLE;
            end
         end
         SEND: begin
            if (xfer) begin
               if (is_last) begin
                  frame_done = 1'b1;
                  beat_next  = 4'd0;
                  state_next = capture ? SEND : IDLE;
               end else begin
                  beat_next = beat + 4'd1;
               end
            end else begin
               beat_next = beat;
            end
         end
         default: begin
            state_next = IDLE;
            beat_next  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         beat      <= 4'd0;
         shift     <= '0;
         frame_cnt <= 16'd0;
      end else begin
         state <= state_next;
         beat  <= beat_next;
         if (capture) begin
            shift <= i_shift;
         end
         if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   // Frame buffer contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            buffer[b] <= i_result[b*LANES*RES_W +: LANES*RES_W];
         end
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: randomized frames against a
// beat-queue reference model built from floor-division requantization.
module tb_result_drain;
   import result_drain_pkg::*;

   logic                     clk;
   logic                     rst;
   logic                     i_valid;
   logic                     o_ready;
   logic [NUM_RES*RES_W-1:0] i_result;
   logic [SHIFT_W-1:0]       i_shift;
   logic                     o_valid;
   logic                     i_ready;
   logic [LANES*OUT_W-1:0]   o_data;
   logic [3:0]               o_beat;
   logic                     o_last;
   logic [15:0]              o_frame_cnt;

   int                       n_cmp;
   int                       n_err;
   logic [LANES*OUT_W-1:0]   q[$];
   logic [15:0]              exp_fc;
   logic [15:0]              fc0;
   bit                       captured;

   result_drain dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_result    (i_result),
      .i_shift     (i_shift),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_beat      (o_beat),
      .o_last      (o_last),
      .o_frame_cnt (o_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference requant: floor(x / 2^s), then clamp to 0..15.
   function automatic logic [3:0] ref_rq(input int x, input int s);
      int p;
      int y;
      p = 1 << s;
      if (x >= 0) y = x / p;
      else        y = -((-x + p - 1) / p);
      if (y < 0)  return 4'd0;
      if (y > 15) return 4'd15;
      return y[3:0];
   endfunction

   task automatic push_frame();
      logic [255:0]      w;
      logic signed [9:0] v;
      for (int b = 0; b < NUM_BEATS; b++) begin
         w = '0;
         for (int l = 0; l < LANES; l++) begin
            v = i_result[(b*LANES + l)*RES_W +: RES_W];
            w[l*OUT_W +: OUT_W] = ref_rq(int'(v), int'(i_shift));
         end
         q.push_back(w);
      end
   endtask

   // One cycle: check outputs against the model, then advance the model.
   task automatic step();
      bit exp_rdy;
      int sz;
      #1;
      sz      = q.size();
      exp_rdy = (sz == 0) || (i_ready && sz == 1);
      check("o_ready", 256'(o_ready), 256'(exp_rdy));
      check("o_valid", 256'(o_valid), 256'(sz != 0));
      if (sz != 0) begin
         check("o_data", 256'(o_data), q[0]);
         check("o_beat", 256'(o_beat), 256'(NUM_BEATS - sz));
         check("o_last", 256'(o_last), 256'(sz == 1));
      end else begin
         check("o_data_idle", 256'(o_data), 256'(0));
      end
      check("o_frame_cnt", 256'(o_frame_cnt), 256'(exp_fc));
      captured = 1'b0;
      if (sz != 0 && i_ready) begin
         void'(q.pop_front());
         if (q.size() == 0) exp_fc++;
      end
      if (i_valid && exp_rdy) begin
         push_frame();
         captured = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic set_all(input int val);
      for (int k = 0; k < NUM_RES; k++) i_result[k*RES_W +: RES_W] = 10'(val);
   endtask

   task automatic set_random();
      for (int k = 0; k < NUM_RES; k++) i_result[k*RES_W +: RES_W] = 10'($urandom);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      exp_fc   = 16'd0;
      captured = 1'b0;
      rst      = 1'b1;
      i_valid  = 1'b0;
      i_ready  = 1'b0;
      i_result = '0;
      i_shift  = 3'd0;
      #2;
      check("rst_valid", 256'(o_valid), 256'(0));
      check("rst_ready", 256'(o_ready), 256'(1));
      check("rst_data", 256'(o_data), 256'(0));
      check("rst_fc", 256'(o_frame_cnt), 256'(0));
      @(negedge clk);
      rst = 1'b0;

      // Basic frame: result k = k mod 16, shift 0, no backpressure.
      for (int k = 0; k < NUM_RES; k++) i_result[k*RES_W +: RES_W] = 10'(k % 16);
      i_shift = 3'd0;
      i_ready = 1'b1;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (15) step();
      check("basic_fc", 256'(o_frame_cnt), 256'(1));

      // Requant corners in lanes 0..5 at shift 0 and shift 2.
      for (int s = 0; s <= 2; s += 2) begin
         set_random();
         i_result[0*RES_W +: RES_W] = 10'h3FF;
         i_result[1*RES_W +: RES_W] = 10'h200;
         i_result[2*RES_W +: RES_W] = 10'd15;
         i_result[3*RES_W +: RES_W] = 10'd16;
         i_result[4*RES_W +: RES_W] = 10'd511;
         i_result[5*RES_W +: RES_W] = 10'd40;
         i_shift = 3'(s);
         i_valid = 1'b1;
         step();
         i_valid = 1'b0;
         check("corner_lanes", 256'(o_data[23:0]), (s == 0) ? 256'(24'hFFFF00) : 256'(24'hAF4300));
         repeat (14) step();
      end

      // Backpressure: random i_ready, producer always holding a fresh frame.
      set_random();
      i_shift = 3'($urandom_range(0, 7));
      i_valid = 1'b1;
      for (int c = 0; c < 300; c++) begin
         i_ready = 1'($urandom_range(0, 1));
         step();
         if (captured) begin
            set_random();
            i_shift = 3'($urandom_range(0, 7));
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (16) step();

      // Chained frames: A (all 5, shift 0) then B (all 9, shift 1) with no gap.
      fc0 = exp_fc;
      set_all(5);
      i_shift = 3'd0;
      i_valid = 1'b1;
      step();
      set_all(9);
      i_shift = 3'd1;
      repeat (14) step();
      check("chain_capture", 256'(captured), 256'(1));
      i_valid = 1'b0;
      repeat (15) step();
      check("chain_fc", 256'(o_frame_cnt), 256'(fc0 + 16'd2));

      // Reset while beat 7 is on the bus.
      set_random();
      i_shift = 3'($urandom_range(0, 7));
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (7) step();
      check("pre_rst_beat", 256'(o_beat), 256'(7));
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 256'(o_valid), 256'(0));
      check("mid_rst_ready", 256'(o_ready), 256'(1));
      check("mid_rst_data", 256'(o_data), 256'(0));
      check("mid_rst_fc", 256'(o_frame_cnt), 256'(0));
      check("mid_rst_beat", 256'(o_beat), 256'(0));
      check("mid_rst_last", 256'(o_last), 256'(0));
      q.delete();
      exp_fc = 16'd0;
      @(negedge clk);
      rst = 1'b0;
      set_random();
      i_shift = 3'($urandom_range(0, 7));
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (15) step();
      check("post_rst_fc", 256'(o_frame_cnt), 256'(1));

      // Counter wrap: preload 0xFFFF, one more frame must wrap to 0.
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      exp_fc = 16'hFFFF;
      @(negedge clk);
      check("wrap_preload", 256'(o_frame_cnt), 256'(16'hFFFF));
      set_random();
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (15) step();
      check("wrap_fc", 256'(o_frame_cnt), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
